// File: rtl/rs_if.sv
// ---------------------------------------------------------------------------
// rs_pkg / rs_if
//
// Shared types for the reservation station, plus the interface that bundles
// its two handshakes:
//   dispatch : disp_valid_rs0, disp_pkt_rs0  (allocator -> RS)
//              rs_stall_rs0                  (RS -> allocator backpressure)
//   issue    : iss_valid_rs1, iss_pkt_rs1    (RS -> execution)
//              exe_ready_rs1                 (execution -> RS)
// The master modport is the allocator/execution side. The slave modport is
// the reservation station itself.
// ---------------------------------------------------------------------------
package rs_pkg;

   typedef logic [6:0] t_prf_id;

   typedef struct packed {
      logic       valid;
      logic [5:0] robid;
   } t_nuke_pkt;

   typedef struct packed {
      logic [15:0] uinstr;
      t_prf_id     pdst;
      t_prf_id     psrc1;
      logic        psrc1_pend;
      t_prf_id     psrc2;
      logic        psrc2_pend;
      logic [5:0]  robid;
   } t_disp_pkt;

endpackage

interface rs_if;
   import rs_pkg::*;

   logic      disp_valid_rs0;
   t_disp_pkt disp_pkt_rs0;
   logic      rs_stall_rs0;
   logic      iss_valid_rs1;
   t_disp_pkt iss_pkt_rs1;
   logic      exe_ready_rs1;

   modport master (
      output disp_valid_rs0,
      output disp_pkt_rs0,
      output exe_ready_rs1,
      input  rs_stall_rs0,
      input  iss_valid_rs1,
      input  iss_pkt_rs1
   );

   modport slave (
      input  disp_valid_rs0,
      input  disp_pkt_rs0,
      input  exe_ready_rs1,
      output rs_stall_rs0,
      output iss_valid_rs1,
      output iss_pkt_rs1
   );

endinterface

// File: rtl/rs.sv
// ---------------------------------------------------------------------------
// rs : reservation station
//
// Buffers renamed uops until their pending sources are woken by writeback
// broadcasts, then selects the oldest ready entry into a registered issue
// slot.
//
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   nuke_rb1       flush; only .valid is looked at
//   rs_io          slave side of rs_if (dispatch in, stall out, issue slot)
//   wb_valid_rb0   per-port writeback wakeup valid
//   wb_pdst_rb0    per-port physical register being written
// ---------------------------------------------------------------------------
module rs
   import rs_pkg::*;
#(
   parameter int NUM_RS_ENTS  = 8,
   parameter int NUM_WB_PORTS = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  t_nuke_pkt               nuke_rb1,
   rs_if.slave                     rs_io,
   input  logic [NUM_WB_PORTS-1:0] wb_valid_rb0,
   input  t_prf_id                 wb_pdst_rb0 [NUM_WB_PORTS]
);

   localparam int IDX_W = $clog2(NUM_RS_ENTS);
   localparam int CNT_W = IDX_W + 1;

   // Clears any pending-source flag whose tag is broadcast this cycle.
   function automatic t_disp_pkt wake(input t_disp_pkt p,
                                      input logic [NUM_WB_PORTS-1:0] v,
                                      input t_prf_id d [NUM_WB_PORTS]);
      t_disp_pkt r;
      r = p;
      for (int w = 0; w < NUM_WB_PORTS; w++) begin
         if (v[w] && d[w] == p.psrc1) r.psrc1_pend = 1'b0;
         if (v[w] && d[w] == p.psrc2) r.psrc2_pend = 1'b0;
      end
      return r;
   endfunction

   logic [NUM_RS_ENTS-1:0] valid_q, valid_d;
   t_disp_pkt              pkt_q [NUM_RS_ENTS];
   t_disp_pkt              pkt_d [NUM_RS_ENTS];
   t_disp_pkt              pkt_wk [NUM_RS_ENTS];
   logic [NUM_RS_ENTS-1:0] age_q [NUM_RS_ENTS];
   logic [NUM_RS_ENTS-1:0] age_d [NUM_RS_ENTS];
   logic                   iss_valid_q, iss_valid_d;
   t_disp_pkt              iss_pkt_q, iss_pkt_d;

   logic [NUM_RS_ENTS-1:0] ready;
   logic [NUM_RS_ENTS-1:0] sel;
   logic                   any_ready;
   t_disp_pkt              sel_pkt;
   logic [CNT_W-1:0]       free_cnt;
   logic [IDX_W-1:0]       alloc_idx;
   logic                   has_free;
   logic                   slot_load;
   logic                   do_alloc;
   t_disp_pkt              nuke_unused;

   assign nuke_unused = t_disp_pkt'(nuke_rb1);

   // Readiness includes this cycle's broadcasts so a woken entry can be
   // selected in the same cycle it is woken.
   always_comb begin
      for (int i = 0; i < NUM_RS_ENTS; i++) begin
         pkt_wk[i] = wake(pkt_q[i], wb_valid_rb0, wb_pdst_rb0);
         ready[i]  = valid_q[i] & ~pkt_wk[i].psrc1_pend & ~pkt_wk[i].psrc2_pend;
      end
   end

   // Oldest-ready select: an entry wins when no other ready entry is older.
   always_comb begin
      sel_pkt = '0;
      for (int i = 0; i < NUM_RS_ENTS; i++) begin
         sel[i] = ready[i];
         for (int j = 0; j < NUM_RS_ENTS; j++) begin
            if (ready[j] && age_q[j][i]) sel[i] = 1'b0;
         end
         if (sel[i]) sel_pkt = pkt_wk[i];
      end
      any_ready = |ready;
   end

   // Free count and lowest-index free entry.
   always_comb begin
      free_cnt  = '0;
      alloc_idx = '0;
      has_free  = 1'b0;
      for (int i = NUM_RS_ENTS - 1; i >= 0; i--) begin
         free_cnt = free_cnt + CNT_W'(!valid_q[i]);
         if (!valid_q[i]) begin
            alloc_idx = IDX_W'(i);
            has_free  = 1'b1;
         end
      end
   end

   // Conservative: an entry freed by this cycle's issue is not counted.
   assign rs_io.rs_stall_rs0  = reset | (free_cnt <= CNT_W'(rs_io.disp_valid_rs0));
   assign rs_io.iss_valid_rs1 = iss_valid_q;
   assign rs_io.iss_pkt_rs1   = iss_pkt_q;

   always_comb begin
      valid_d     = valid_q;
      pkt_d       = pkt_wk;
      age_d       = age_q;
      iss_valid_d = iss_valid_q;
      iss_pkt_d   = iss_pkt_q;
      slot_load   = ~iss_valid_q | rs_io.exe_ready_rs1;
      do_alloc    = rs_io.disp_valid_rs0 & ~nuke_rb1.valid & has_free;

      if (slot_load) begin
         iss_valid_d = any_ready;
         if (any_ready) iss_pkt_d = sel_pkt;
         valid_d = valid_d & ~sel;
      end

      // New entry is older than nothing; every resident entry is older than it.
      if (do_alloc) begin
         valid_d[alloc_idx] = 1'b1;
         pkt_d[alloc_idx]   = wake(rs_io.disp_pkt_rs0, wb_valid_rb0, wb_pdst_rb0);
         age_d[alloc_idx]   = '0;
         for (int j = 0; j < NUM_RS_ENTS; j++) begin
            age_d[j][alloc_idx] = valid_q[j];
         end
      end

      if (nuke_rb1.valid) begin
         valid_d     = '0;
         iss_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q     <= '0;
         iss_valid_q <= 1'b0;
         iss_pkt_q   <= '0;
         for (int i = 0; i < NUM_RS_ENTS; i++) begin
            pkt_q[i] <= '0;
            age_q[i] <= '0;
         end
      end else begin
         valid_q     <= valid_d;
         iss_valid_q <= iss_valid_d;
         iss_pkt_q   <= iss_pkt_d;
         pkt_q       <= pkt_d;
         age_q       <= age_d;
      end
   end

`ifdef ASSERT
   a_no_disp_when_full: assert property (@(posedge clk) disable iff (reset)
      !(rs_io.disp_valid_rs0 && !nuke_rb1.valid && free_cnt == '0));
`endif

endmodule
